// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipe_stage_chain handshake, control and status signals.
// The master modport is the producer/controller side; the slave modport is the chain itself.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
);
  logic [DATA_W-1:0] InData;
  logic [CTRL_W-1:0] InCtrl;
  logic              InValid;
  logic              InReady;
  logic [DEPTH-1:0]  Stall;
  logic [DEPTH-1:0]  Flush;
  logic              ClearCount;
  logic [DATA_W-1:0] OutData;
  logic [CTRL_W-1:0] OutCtrl;
  logic              OutValid;
  logic [DEPTH-1:0]  StageValid;
  logic [15:0]       StallCount;

  modport master (
    output InData, InCtrl, InValid, Stall, Flush, ClearCount,
    input  InReady, OutData, OutCtrl, OutValid, StageValid, StallCount
  );

  modport slave (
    input  InData, InCtrl, InValid, Stall, Flush, ClearCount,
    output InReady, OutData, OutCtrl, OutValid, StageValid, StallCount
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH chained pipeline registers with per-stage stall/flush; DEPTH cycles latency, bubble under a stalled stage.
// Backpressure: any stall at or below stage k freezes stage k; InReady drops combinationally when stage 0 is frozen.
module pipe_stage_chain #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 8,
  parameter int                DEPTH       = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input logic               Clk,
  input logic               Reset,
  pipe_stage_chain_if.slave bus
);
  logic [DEPTH-1:0][DATA_W-1:0] dataQ;
  logic [DEPTH-1:0][DATA_W-1:0] srcData;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrlQ;
  logic [DEPTH-1:0][CTRL_W-1:0] srcCtrl;
  logic [DEPTH-1:0]             validQ;
  logic [DEPTH-1:0]             srcValid;
  logic [DEPTH-1:0]             hold;
  logic [DEPTH-1:0]             bubbleIn;
  logic [15:0]                  stallCnt;

  for (genvar k = 0; k < DEPTH; k++) begin : gLink
    assign hold[k] = |bus.Stall[DEPTH-1:k];
    if (k == 0) begin : gHead
      // An invalid input is normalised to a bubble so ctrl never carries stray bits.
      assign srcValid[0] = bus.InValid;
      assign srcData[0]  = bus.InValid ? bus.InData : '0;
      assign srcCtrl[0]  = bus.InValid ? bus.InCtrl : CTRL_BUBBLE;
      assign bubbleIn[0] = 1'b0;
    end else begin : gBody
      assign srcValid[k] = validQ[k-1];
      assign srcData[k]  = dataQ[k-1];
      assign srcCtrl[k]  = ctrlQ[k-1];
      assign bubbleIn[k] = hold[k-1];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dataQ  <= '0;
      ctrlQ  <= {DEPTH{CTRL_BUBBLE}};
      validQ <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.Flush[k] || (!hold[k] && bubbleIn[k])) begin
          dataQ[k]  <= '0;
          ctrlQ[k]  <= CTRL_BUBBLE;
          validQ[k] <= 1'b0;
        end else if (!hold[k]) begin
          dataQ[k]  <= srcData[k];
          ctrlQ[k]  <= srcCtrl[k];
          validQ[k] <= srcValid[k];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCnt <= '0;
    end else if (bus.ClearCount) begin
      stallCnt <= '0;
    end else if ((|bus.Stall) && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign bus.InReady    = ~hold[0];
  assign bus.OutData    = dataQ[DEPTH-1];
  assign bus.OutCtrl    = ctrlQ[DEPTH-1];
  assign bus.OutValid   = validQ[DEPTH-1];
  assign bus.StageValid = validQ;
  assign bus.StallCount = stallCnt;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised and directed checks of pipe_stage_chain against a cycle-level reference model.
module tb_pipe_stage_chain;
  logic Clk = 1'b0;
  logic Reset;
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  pipe_stage_chain_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) a ();
  pipe_stage_chain_if #(.DATA_W(64), .CTRL_W(8), .DEPTH(1)) b ();

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CTRL_BUBBLE(8'h00))
    dutA (.Clk(Clk), .Reset(Reset), .bus(a));
  pipe_stage_chain #(.DATA_W(64), .CTRL_W(8), .DEPTH(1), .CTRL_BUBBLE(8'h5A))
    dutB (.Clk(Clk), .Reset(Reset), .bus(b));

  // Reference model of the DEPTH=3 instance
  logic [31:0] mData [3];
  logic [7:0]  mCtrl [3];
  logic [2:0]  mValid;
  int          mCnt;

  function automatic void modelReset();
    for (int k = 0; k < 3; k++) begin
      mData[k] = '0;
      mCtrl[k] = 8'h00;
    end
    mValid = '0;
    mCnt   = 0;
  endfunction

  function automatic void modelStep();
    logic [31:0] pd [3];
    logic [7:0]  pc [3];
    logic [2:0]  pv;
    bit frozen;
    bit starved;
    pd = mData;
    pc = mCtrl;
    pv = mValid;
    for (int k = 0; k < 3; k++) begin
      frozen  = (a.Stall >> k) != 3'b000;
      starved = (k > 0) && ((a.Stall >> (k - 1)) != 3'b000);
      if (a.Flush[k] || (!frozen && starved)) begin
        mData[k] = '0; mCtrl[k] = 8'h00; mValid[k] = 1'b0;
      end else if (!frozen) begin
        if (k == 0) begin
          mValid[0] = a.InValid;
          mData[0]  = a.InValid ? a.InData : 32'h0;
          mCtrl[0]  = a.InValid ? a.InCtrl : 8'h00;
        end else begin
          mData[k] = pd[k-1]; mCtrl[k] = pc[k-1]; mValid[k] = pv[k-1];
        end
      end
    end
    if (a.ClearCount) mCnt = 0;
    else if (a.Stall != 3'b000 && mCnt < 65535) mCnt = mCnt + 1;
  endfunction

  task automatic tick();
    @(posedge Clk);
    modelStep();
    #1;
  endtask

  task automatic driveA(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic [2:0] st, input logic [2:0] fl);
    a.InValid = v; a.InData = d; a.InCtrl = c; a.Stall = st; a.Flush = fl;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    driveA(1'b0, 32'h0, 8'h0, 3'b000, 3'b000);
    a.ClearCount = 1'b0;
    b.InValid = 1'b0; b.InData = '0; b.InCtrl = '0; b.Stall = '0; b.Flush = '0; b.ClearCount = 1'b0;
    modelReset();
    #22;
    vectors++; if (a.OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_outvalid got %0b want 0", a.OutValid); end
    vectors++; if (a.StageValid !== 3'b000) begin miscompares++; $display("FAIL reset_stagevalid got %b want 000", a.StageValid); end
    vectors++; if (a.OutData !== 32'h0) begin miscompares++; $display("FAIL reset_outdata got %h want 0", a.OutData); end
    vectors++; if (a.OutCtrl !== 8'h00) begin miscompares++; $display("FAIL reset_outctrl got %h want 00", a.OutCtrl); end
    vectors++; if (a.StallCount !== 16'h0) begin miscompares++; $display("FAIL reset_count got %h want 0", a.StallCount); end
    vectors++; if (b.OutCtrl !== 8'h5A) begin miscompares++; $display("FAIL reset_b_outctrl got %h want 5a", b.OutCtrl); end
    vectors++; if (a.InReady !== 1'b1) begin miscompares++; $display("FAIL reset_inready got %0b want 1", a.InReady); end
    #1 Reset = 1'b0;
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 6; c++) begin
      driveA(c < 3, 32'h10 + c, 8'h80 + c[7:0], 3'b000, 3'b000);
      tick();
      begin
        int n;
        bit  expV;
        n = c + 1 - 3;
        expV = (n >= 0) && (n < 3);
        vectors++; if (a.OutValid !== expV) begin miscompares++; $display("FAIL stream_valid cyc %0d got %0b want %0b", c + 1, a.OutValid, expV); end
        vectors++; if (a.OutData !== (expV ? 32'h10 + n : 32'h0)) begin miscompares++; $display("FAIL stream_data cyc %0d got %h want %h", c + 1, a.OutData, expV ? 32'h10 + n : 32'h0); end
        vectors++; if (a.OutCtrl !== (expV ? 8'h80 + n[7:0] : 8'h00)) begin miscompares++; $display("FAIL stream_ctrl cyc %0d got %h", c + 1, a.OutCtrl); end
      end
    end
  endtask

  task automatic fillABC();
    driveA(1'b1, 32'hAAAA_0003, 8'h33, 3'b000, 3'b000); tick();
    driveA(1'b1, 32'hAAAA_0002, 8'h22, 3'b000, 3'b000); tick();
    driveA(1'b1, 32'hAAAA_0001, 8'h11, 3'b000, 3'b000); tick();
  endtask

  task automatic test_stall_bubble();
    fillABC();
    vectors++; if (a.OutData !== 32'hAAAA_0003) begin miscompares++; $display("FAIL fill_outdata got %h want aaaa0003", a.OutData); end
    vectors++; if (a.StageValid !== 3'b111) begin miscompares++; $display("FAIL fill_stagevalid got %b want 111", a.StageValid); end
    driveA(1'b1, 32'hAAAA_0004, 8'h44, 3'b010, 3'b000);
    #1;
    vectors++; if (a.InReady !== 1'b0) begin miscompares++; $display("FAIL stall_inready got %0b want 0", a.InReady); end
    tick();
    vectors++; if (a.StageValid !== 3'b011) begin miscompares++; $display("FAIL stall_stagevalid got %b want 011", a.StageValid); end
    vectors++; if (a.OutData !== 32'h0) begin miscompares++; $display("FAIL stall_bubble_data got %h want 0", a.OutData); end
    vectors++; if (a.OutCtrl !== 8'h00) begin miscompares++; $display("FAIL stall_bubble_ctrl got %h want 00", a.OutCtrl); end
    driveA(1'b1, 32'hAAAA_0004, 8'h44, 3'b000, 3'b000);
    tick();
    vectors++; if (a.OutData !== 32'hAAAA_0002 || a.OutValid !== 1'b1) begin miscompares++; $display("FAIL release_b got %h/%0b want aaaa0002/1", a.OutData, a.OutValid); end
    driveA(1'b0, 32'h0, 8'h0, 3'b000, 3'b000);
    tick();
    vectors++; if (a.OutData !== 32'hAAAA_0001) begin miscompares++; $display("FAIL release_a got %h want aaaa0001", a.OutData); end
    tick();
    vectors++; if (a.OutData !== 32'hAAAA_0004 || a.OutCtrl !== 8'h44) begin miscompares++; $display("FAIL release_d got %h/%h want aaaa0004/44", a.OutData, a.OutCtrl); end
  endtask

  task automatic test_flush_vs_stall();
    fillABC();
    driveA(1'b1, 32'hAAAA_0004, 8'h44, 3'b010, 3'b010);
    tick();
    vectors++; if (a.StageValid !== 3'b001) begin miscompares++; $display("FAIL flushstall_stagevalid got %b want 001", a.StageValid); end
    vectors++; if (a.OutValid !== 1'b0 || a.OutCtrl !== 8'h00) begin miscompares++; $display("FAIL flushstall_out got %0b/%h want 0/00", a.OutValid, a.OutCtrl); end
    driveA(1'b1, 32'hAAAA_0004, 8'h44, 3'b010, 3'b000);
    tick();
    vectors++; if (a.StageValid !== 3'b001) begin miscompares++; $display("FAIL held_bubble_stagevalid got %b want 001", a.StageValid); end
    driveA(1'b0, 32'h0, 8'h0, 3'b000, 3'b000);
    tick();
    vectors++; if (a.StageValid !== 3'b010) begin miscompares++; $display("FAIL flush_release_stagevalid got %b want 010", a.StageValid); end
    tick();
    vectors++; if (a.OutData !== 32'hAAAA_0001 || a.OutCtrl !== 8'h11 || a.OutValid !== 1'b1) begin miscompares++; $display("FAIL flush_release_a got %h/%h/%0b want aaaa0001/11/1", a.OutData, a.OutCtrl, a.OutValid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] st;
      logic [2:0] fl;
      for (int k = 0; k < 3; k++) begin
        st[k] = ($urandom_range(0, 3) == 0);
        fl[k] = ($urandom_range(0, 7) == 0);
      end
      driveA($urandom_range(0, 3) != 0, $urandom, 8'($urandom), st, fl);
      a.ClearCount = ($urandom_range(0, 31) == 0);
      #1;
      vectors++; if (a.InReady !== (st == 3'b000)) begin miscompares++; $display("FAIL rnd_inready #%0d got %0b stall %b", i, a.InReady, st); end
      tick();
      vectors++; if (a.OutData !== mData[2]) begin miscompares++; $display("FAIL rnd_data #%0d got %h want %h", i, a.OutData, mData[2]); end
      vectors++; if (a.OutCtrl !== mCtrl[2]) begin miscompares++; $display("FAIL rnd_ctrl #%0d got %h want %h", i, a.OutCtrl, mCtrl[2]); end
      vectors++; if (a.OutValid !== mValid[2]) begin miscompares++; $display("FAIL rnd_valid #%0d got %0b want %0b", i, a.OutValid, mValid[2]); end
      vectors++; if (a.StageValid !== mValid) begin miscompares++; $display("FAIL rnd_stagevalid #%0d got %b want %b", i, a.StageValid, mValid); end
      vectors++; if (a.StallCount !== mCnt[15:0]) begin miscompares++; $display("FAIL rnd_count #%0d got %0d want %0d", i, a.StallCount, mCnt); end
    end
    a.ClearCount = 1'b0;
  endtask

  task automatic test_counter();
    driveA(1'b0, 32'h0, 8'h0, 3'b000, 3'b000);
    a.ClearCount = 1'b1;
    tick();
    vectors++; if (a.StallCount !== 16'h0) begin miscompares++; $display("FAIL cnt_clear got %h want 0", a.StallCount); end
    a.ClearCount = 1'b0;
    a.Stall = 3'b001;
    repeat (65534) tick();
    vectors++; if (a.StallCount !== 16'hFFFE) begin miscompares++; $display("FAIL cnt_fffe got %h want fffe", a.StallCount); end
    tick();
    vectors++; if (a.StallCount !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_ffff got %h want ffff", a.StallCount); end
    repeat (4465) tick();
    vectors++; if (a.StallCount !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_saturate got %h want ffff", a.StallCount); end
    a.ClearCount = 1'b1;
    tick();
    vectors++; if (a.StallCount !== 16'h0) begin miscompares++; $display("FAIL cnt_clear_prio got %h want 0", a.StallCount); end
    a.ClearCount = 1'b0;
    tick();
    vectors++; if (a.StallCount !== 16'h1) begin miscompares++; $display("FAIL cnt_after_clear got %h want 1", a.StallCount); end
    a.Stall = 3'b000;
  endtask

  task automatic test_depth1();
    b.InValid = 1'b1; b.InData = 64'hDEAD_BEEF_0000_0001; b.InCtrl = 8'h33;
    tick();
    vectors++; if (b.OutData !== 64'hDEAD_BEEF_0000_0001 || b.OutValid !== 1'b1 || b.OutCtrl !== 8'h33) begin miscompares++; $display("FAIL d1_load got %h/%0b/%h", b.OutData, b.OutValid, b.OutCtrl); end
    b.Stall = 1'b1; b.InData = 64'h1234_5678_9ABC_DEF0; b.InCtrl = 8'h77;
    #1;
    vectors++; if (b.InReady !== 1'b0) begin miscompares++; $display("FAIL d1_inready got %0b want 0", b.InReady); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (b.OutData !== 64'hDEAD_BEEF_0000_0001 || b.OutValid !== 1'b1) begin miscompares++; $display("FAIL d1_hold edge %0d got %h/%0b", i, b.OutData, b.OutValid); end
    end
    b.Flush = 1'b1;
    tick();
    vectors++; if (b.OutValid !== 1'b0 || b.OutCtrl !== 8'h5A || b.OutData !== 64'h0) begin miscompares++; $display("FAIL d1_flush got %0b/%h/%h want 0/5a/0", b.OutValid, b.OutCtrl, b.OutData); end
    vectors++; if (b.StallCount !== 16'd6) begin miscompares++; $display("FAIL d1_count got %0d want 6", b.StallCount); end
    b.Flush = 1'b0; b.Stall = 1'b0; b.InValid = 1'b0;
    tick();
    vectors++; if (b.OutCtrl !== 8'h5A || b.OutValid !== 1'b0 || b.OutData !== 64'h0) begin miscompares++; $display("FAIL d1_invalid_in got %h/%0b/%h want 5a/0/0", b.OutCtrl, b.OutValid, b.OutData); end
  endtask

  task automatic test_reset_midstream();
    fillABC();
    driveA(1'b1, 32'h5555_0000, 8'h55, 3'b100, 3'b000);
    tick();
    vectors++; if (a.StageValid !== 3'b111) begin miscompares++; $display("FAIL mid_pre_stagevalid got %b want 111", a.StageValid); end
    vectors++; if (a.StallCount !== mCnt[15:0]) begin miscompares++; $display("FAIL mid_pre_count got %0d want %0d", a.StallCount, mCnt); end
    driveA(1'b0, 32'h0, 8'h0, 3'b000, 3'b000);
    Reset = 1'b1;
    #2;
    vectors++; if (a.OutValid !== 1'b0 || a.StageValid !== 3'b000) begin miscompares++; $display("FAIL mid_valid got %0b/%b want 0/000", a.OutValid, a.StageValid); end
    vectors++; if (a.StallCount !== 16'h0 || a.OutCtrl !== 8'h00 || a.OutData !== 32'h0) begin miscompares++; $display("FAIL mid_state got %h/%h/%h want 0/00/0", a.StallCount, a.OutCtrl, a.OutData); end
    Reset = 1'b0;
    modelReset();
    driveA(1'b1, 32'h6666_0000, 8'h66, 3'b000, 3'b000);
    tick();
    vectors++; if (a.StageValid !== 3'b001) begin miscompares++; $display("FAIL mid_restart got %b want 001", a.StageValid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_stall_bubble();
    test_flush_vs_stall();
    test_random();
    test_counter();
    test_depth1();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
